// File: rtl/phy_tx_if.sv
// Upstream byte interface of the two-lane transmit PHY: per-lane data/valid
// driven by the producer, word_tick returned to say when they are sampled.
interface phy_tx_if;
  logic [7:0] data_in_0;
  logic       valid_in_0;
  logic [7:0] data_in_1;
  logic       valid_in_1;
  logic       word_tick;

  modport master (output data_in_0, output valid_in_0, output data_in_1,
                  output valid_in_1, input word_tick);
  modport slave  (input data_in_0, input valid_in_0, input data_in_1,
                  input valid_in_1, output word_tick);
endinterface

// File: rtl/phy_tx.sv
// Two-lane serialising transmit PHY: COM preamble after enable, then data/IDLE words MSB-first.
// Optional build macro PHY_TX_WORD_CNT_EN adds saturating per-lane valid-word counters.
module phy_tx #(
  parameter logic [3:0] SYNC_WORDS = 4'd4,
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDLE_SYM   = 8'h7C
) (
  input  logic        clk_8f,
  input  logic        reset_L,
  input  logic        enable,
  phy_tx_if.slave     tx,
  output logic        out_0,
  output logic        out_1,
`ifdef PHY_TX_WORD_CNT_EN
  output logic [15:0] tx_cnt_0,
  output logic [15:0] tx_cnt_1,
`endif
  output logic        active
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] sh_0_q, sh_0_d;
  logic [7:0] sh_1_q, sh_1_d;
  logic       active_q, active_d;
  logic       boundary_s;
  logic       word_tick_s;
  logic [7:0] load_0_s;
  logic [7:0] load_1_s;

  // Word boundary, input sampling strobe and the per-lane word offered at a sample.
  always_comb begin
    boundary_s  = (bit_cnt_q == 3'd7);
    word_tick_s = boundary_s && enable &&
                  ((state_q == ST_ACTIVE) ||
                   ((state_q == ST_SYNC) && (sync_cnt_q == SYNC_WORDS)));
    load_0_s    = tx.valid_in_0 ? tx.data_in_0 : IDLE_SYM;
    load_1_s    = tx.valid_in_1 ? tx.data_in_1 : IDLE_SYM;
  end

  // Next-state logic; dropping enable aborts mid-word with no completion.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    sh_0_d     = sh_0_q;
    sh_1_d     = sh_1_q;
    active_d   = active_q;
    if (!enable) begin
      state_d    = ST_DISABLED;
      bit_cnt_d  = 3'd0;
      sync_cnt_d = 4'd0;
      sh_0_d     = 8'h00;
      sh_1_d     = 8'h00;
      active_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d    = ST_SYNC;
          bit_cnt_d  = 3'd0;
          sync_cnt_d = 4'd1;
          sh_0_d     = COM_SYM;
          sh_1_d     = COM_SYM;
          active_d   = 1'b0;
        end
        ST_SYNC: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (!boundary_s) begin
            sh_0_d = {sh_0_q[6:0], 1'b0};
            sh_1_d = {sh_1_q[6:0], 1'b0};
          end else if (sync_cnt_q < SYNC_WORDS) begin
            sh_0_d     = COM_SYM;
            sh_1_d     = COM_SYM;
            sync_cnt_d = sync_cnt_q + 4'd1;
          end else begin
            sh_0_d   = load_0_s;
            sh_1_d   = load_1_s;
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end
        end
        ST_ACTIVE: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          active_d  = 1'b1;
          if (boundary_s) begin
            sh_0_d = load_0_s;
            sh_1_d = load_1_s;
          end else begin
            sh_0_d = {sh_0_q[6:0], 1'b0};
            sh_1_d = {sh_1_q[6:0], 1'b0};
          end
        end
        default: begin
          state_d    = ST_DISABLED;
          bit_cnt_d  = 3'd0;
          sync_cnt_d = 4'd0;
          sh_0_d     = 8'h00;
          sh_1_d     = 8'h00;
          active_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and lane shift registers.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_DISABLED;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 4'd0;
      sh_0_q     <= 8'h00;
      sh_1_q     <= 8'h00;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      sh_0_q     <= sh_0_d;
      sh_1_q     <= sh_1_d;
      active_q   <= active_d;
    end
  end

  assign out_0        = sh_0_q[7];
  assign out_1        = sh_1_q[7];
  assign active       = active_q;
  assign tx.word_tick = word_tick_s;

`ifdef PHY_TX_WORD_CNT_EN
  logic [15:0] cnt_0_q, cnt_0_d;
  logic [15:0] cnt_1_q, cnt_1_d;

  // Saturating count of valid words loaded per lane; survives enable toggles.
  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (word_tick_s && tx.valid_in_0 && (cnt_0_q != 16'hFFFF)) begin
      cnt_0_d = cnt_0_q + 16'd1;
    end else begin
      cnt_0_d = cnt_0_q;
    end
    if (word_tick_s && tx.valid_in_1 && (cnt_1_q != 16'hFFFF)) begin
      cnt_1_d = cnt_1_q + 16'd1;
    end else begin
      cnt_1_d = cnt_1_q;
    end
  end

  // Word counter registers, cleared only by reset.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_0_q <= 16'd0;
      cnt_1_q <= 16'd0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign tx_cnt_0 = cnt_0_q;
  assign tx_cnt_1 = cnt_1_q;
`endif

endmodule

// File: tb/tb_phy_tx.sv
// Randomised bench for phy_tx: the driver predicts each lane's serial stream from
// a word-level model and queues it; independent monitors compare DUT outputs.
module tb_phy_tx;
  localparam logic [3:0] SW   = 4'd4;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         NCYC = 1500;

  logic clk_8f  = 1'b0;
  logic reset_L = 1'b0;
  logic enable  = 1'b0;
  logic out_0, out_1, active;
`ifdef PHY_TX_WORD_CNT_EN
  logic [15:0] tx_cnt_0, tx_cnt_1;
`endif

  phy_tx_if tx ();

  phy_tx #(.SYNC_WORDS(SW), .COM_SYM(COM), .IDLE_SYM(IDLE)) dut (
    .clk_8f  (clk_8f),
    .reset_L (reset_L),
    .enable  (enable),
    .tx      (tx),
    .out_0   (out_0),
    .out_1   (out_1),
`ifdef PHY_TX_WORD_CNT_EN
    .tx_cnt_0(tx_cnt_0),
    .tx_cnt_1(tx_cnt_1),
`endif
    .active  (active)
  );

  always #5 clk_8f = ~clk_8f;

  typedef struct packed {
    logic o0;
    logic o1;
    logic act;
  } exp_t;

  exp_t exp_q[$];
  logic wt_q[$];
  bit   running = 1'b0;
  int   checks  = 0;
  int   passes  = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Serial-output monitor: one expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_8f);
      #1;
      if (running) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL exp_queue: got empty queue expected an entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("out_0", 16'(out_0), 16'(e.o0));
          check("out_1", 16'(out_1), 16'(e.o1));
          check("active", 16'(active), 16'(e.act));
        end
      end
    end
  end

  // word_tick monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    logic w;
    forever begin
      @(negedge clk_8f);
      #1;
      if (running) begin
        if (wt_q.size() == 0) begin
          checks++;
          $display("FAIL wt_queue: got empty queue expected an entry at %0t", $time);
        end else begin
          w = wt_q.pop_front();
          check("word_tick", 16'(tx.word_tick), 16'(w));
        end
      end
    end
  end

  // Driver and word-level reference model.
  initial begin
    int         en_cycles = 0;   // edges since enable was first seen high
    int         dis_cnt   = 0;
    int         dir_idx   = 0;
    int         cnt0_m    = 0;
    int         cnt1_m    = 0;
    bit         dropped_once = 1'b0;
    bit         reset_once   = 1'b0;
    bit         do_reset;
    logic       tick;
    logic [7:0] cur0 = 8'h00;
    logic [7:0] cur1 = 8'h00;
    int         b;
    logic       dv0 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] dd0 [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
    logic       dv1 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] dd1 [4] = '{8'h3C, 8'h00, 8'hFF, 8'h81};

    tx.data_in_0  = 8'h00;
    tx.valid_in_0 = 1'b0;
    tx.data_in_1  = 8'h00;
    tx.valid_in_1 = 1'b0;
    #2;
    check("reset_out_0", 16'(out_0), 16'd0);
    check("reset_out_1", 16'(out_1), 16'd0);
    check("reset_active", 16'(active), 16'd0);
    check("reset_word_tick", 16'(tx.word_tick), 16'd0);
    @(negedge clk_8f);
    reset_L = 1'b1;
    running = 1'b1;

    for (int n = 0; n < NCYC; n++) begin
      if (n > 0) @(negedge clk_8f);
      do_reset = 1'b0;
      if (!enable) begin
        dis_cnt++;
        if (dis_cnt >= 3) begin
          enable  = 1'b1;
          dis_cnt = 0;
        end
      end else if (!dropped_once && dir_idx >= 4 && en_cycles % 8 == 4 &&
                   (en_cycles - 1) / 8 >= int'(SW)) begin
        enable       = 1'b0;
        dropped_once = 1'b1;
      end else if (dropped_once && !reset_once && en_cycles == 20) begin
        do_reset   = 1'b1;
        reset_once = 1'b1;
      end else if (reset_once && $urandom_range(0, 299) == 0) begin
        enable = 1'b0;
      end

      tick = enable && (en_cycles % 8 == 0) && (en_cycles / 8 >= int'(SW));
      if (tick && dir_idx < 4) begin
        tx.valid_in_0 = dv0[dir_idx];
        tx.data_in_0  = dd0[dir_idx];
        tx.valid_in_1 = dv1[dir_idx];
        tx.data_in_1  = dd1[dir_idx];
        dir_idx++;
      end else begin
        tx.valid_in_0 = 1'($urandom_range(0, 1));
        tx.data_in_0  = 8'($urandom);
        tx.valid_in_1 = 1'($urandom_range(0, 1));
        tx.data_in_1  = 8'($urandom);
      end
      wt_q.push_back(tick);

      if (do_reset) begin
        #2 reset_L = 1'b0;
        #1;
        check("async_reset_out_0", 16'(out_0), 16'd0);
        check("async_reset_out_1", 16'(out_1), 16'd0);
        check("async_reset_active", 16'(active), 16'd0);
        #1 reset_L = 1'b1;
        en_cycles = 0;
      end

      if (!enable) begin
        en_cycles = 0;
        exp_q.push_back('{o0: 1'b0, o1: 1'b0, act: 1'b0});
      end else begin
        if (en_cycles % 8 == 0) begin
          if (en_cycles / 8 < int'(SW)) begin
            cur0 = COM;
            cur1 = COM;
          end else begin
            cur0 = tx.valid_in_0 ? tx.data_in_0 : IDLE;
            cur1 = tx.valid_in_1 ? tx.data_in_1 : IDLE;
            if (tx.valid_in_0 && cnt0_m < 65535) cnt0_m++;
            if (tx.valid_in_1 && cnt1_m < 65535) cnt1_m++;
          end
        end
        b = 7 - (en_cycles % 8);
        en_cycles++;
        exp_q.push_back('{o0: cur0[b], o1: cur1[b], act: ((en_cycles - 1) / 8 >= int'(SW))});
      end
    end

    @(posedge clk_8f);
    #3;
    running = 1'b0;
    enable  = 1'b0;
    check("exp_queue_drained", 16'(exp_q.size()), 16'd0);
    check("dir_words_sent", 16'(dir_idx), 16'd4);
    check("drop_and_reset_seen", 16'({dropped_once, reset_once}), 16'd3);
`ifdef PHY_TX_WORD_CNT_EN
    check("tx_cnt_0", tx_cnt_0, 16'(cnt0_m));
    check("tx_cnt_1", tx_cnt_1, 16'(cnt1_m));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
